// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-to-execute issue control with long-latency scoreboard and fence.i/WFI/priv sequencing.
// Optional ISSUE_CTRL_PERF_EN adds hazard-stall and fence-drain cycle counters.
module issue_ctrl #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       id_valid_i,
  input  logic [4:0] rs1_idx_i,
  input  logic [4:0] rs2_idx_i,
  input  logic [4:0] rd_idx_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic       rd_wr_en_i,
  input  logic       long_lat_i,
  input  logic       fencei_i,
  input  logic       wfi_i,
  input  logic       priv_i,
  input  logic       ex_ready_i,
  input  logic       flush_i,
  input  logic       wb_long_valid_i,
  input  logic [4:0] wb_long_idx_i,
  input  logic       lsu_idle_i,
  input  logic       irq_pending_i,
  input  logic       icache_flush_ack_i,
  output logic       issue_o,
  output logic       id_stall_o,
  output logic       icache_flush_o,
  output logic       redirect_o,
  output logic       wfi_sleep_o,
  output logic       sb_err_o
`ifdef ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_hazard_cyc_o,
  output logic [31:0] perf_fence_cyc_o
`endif
);
  typedef enum logic [1:0] {RUN, DRAIN, FLUSH, WFI} state_t;
  state_t      state_q, state_d;
  logic [31:0] sb_q, sb_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        kind_q, kind_d, fl_q, fl_d, err_q, err_d;
  logic        hazard, full, drained, issue, redirect, long_issue;
  assign hazard  = (rs1_used_i & sb_q[rs1_idx_i]) | (rs2_used_i & sb_q[rs2_idx_i]) | (rd_wr_en_i & sb_q[rd_idx_i]);
  assign full    = long_lat_i & (cnt_q == 3'(MAX_OUTSTANDING));
  assign drained = (cnt_q == 3'd0) & lsu_idle_i & ex_ready_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      sb_q    <= '0;
      cnt_q   <= '0;
      kind_q  <= 1'b0;
      fl_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      fl_q    <= fl_d;
      err_q   <= err_d;
    end
  end
  // kind_q: 1 = fence.i (needs I-cache flush), 0 = ecall/ebreak/mret
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    fl_d    = fl_q;
    case (state_q)
      RUN: begin
        if (id_valid_i & ~flush_i & (fencei_i | priv_i)) begin
          state_d = DRAIN;
          kind_d  = fencei_i;
        end else if (id_valid_i & ~flush_i & wfi_i & ~irq_pending_i) state_d = WFI;
      end
      DRAIN: state_d = flush_i ? RUN : ~drained ? DRAIN : kind_q ? FLUSH : RUN;
      FLUSH: begin
        fl_d    = (fl_q | flush_i) & ~icache_flush_ack_i;
        state_d = icache_flush_ack_i ? RUN : FLUSH;
      end
      default: state_d = (flush_i | (irq_pending_i & ex_ready_i)) ? RUN : WFI;
    endcase
  end
  always_comb begin
    issue = (state_q == RUN)   ? id_valid_i & ex_ready_i & ~hazard & ~full & ~flush_i & ~fencei_i & ~priv_i & (~wfi_i | irq_pending_i) :
            (state_q == DRAIN) ? ~flush_i & drained & ~kind_q :
            (state_q == FLUSH) ? icache_flush_ack_i & ~fl_q & ~flush_i :
                                 ~flush_i & irq_pending_i & ex_ready_i;
    redirect = (state_q == FLUSH) & icache_flush_ack_i & ~fl_q & ~flush_i;
  end
  assign issue_o        = ~rst_i & issue;
  assign redirect_o     = ~rst_i & redirect;
  assign id_stall_o     = ~rst_i & ((state_q != RUN) | (id_valid_i & ~issue));
  assign icache_flush_o = ~rst_i & (state_q == FLUSH);
  assign wfi_sleep_o    = ~rst_i & (state_q == WFI);
  assign sb_err_o       = ~rst_i & err_q;
  assign long_issue     = issue & long_lat_i;
  // Set is applied after clear so an issue and a retire to the same rd leave the bit set.
  always_comb begin
    sb_d = sb_q;
    if (wb_long_valid_i) sb_d[wb_long_idx_i] = 1'b0;
    if (long_issue & rd_wr_en_i & (rd_idx_i != 5'd0)) sb_d[rd_idx_i] = 1'b1;
    sb_d[0] = 1'b0;
    cnt_d = (long_issue == wb_long_valid_i) ? cnt_q :
            long_issue                     ? cnt_q + 3'd1 :
            (cnt_q == 3'd0)                ? cnt_q : cnt_q - 3'd1;
    err_d = err_q | (wb_long_valid_i & (cnt_q == 3'd0));
  end
`ifdef ISSUE_CTRL_PERF_EN
  logic [31:0] perf_haz_q, perf_haz_d, perf_fen_q, perf_fen_d;
  always_comb begin
    perf_haz_d = perf_haz_q + 32'((state_q == RUN) & id_valid_i & (hazard | full) & ~issue & ~(&perf_haz_q));
    perf_fen_d = perf_fen_q + 32'(((state_q == DRAIN) | (state_q == FLUSH)) & ~(&perf_fen_q));
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_haz_q <= '0;
      perf_fen_q <= '0;
    end else begin
      perf_haz_q <= perf_haz_d;
      perf_fen_q <= perf_fen_d;
    end
  end
  assign perf_hazard_cyc_o = perf_haz_q;
  assign perf_fence_cyc_o  = perf_fen_q;
`endif
endmodule
